// File: rtl/sram_fifo_pkg.sv
// Shared defaults and helpers for the SRAM-backed streaming FIFO.
package sram_fifo_pkg;

    localparam int NBITS_DEFAULT  = 32;
    localparam int NWORDS_DEFAULT = 512;

    // A read may be issued only if the skid can still absorb its data next cycle.
    function automatic logic skid_has_room(input logic [1:0] skid_cnt,
                                           input logic       inflight,
                                           input logic       pop);
        return ({1'b0, skid_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/sram_fifo_if.sv
// Producer/consumer stream bundle for sram_fifo; master drives pushes and pops.
interface sram_fifo_if import sram_fifo_pkg::*; #(
    parameter int nbits  = NBITS_DEFAULT,
    parameter int nwords = NWORDS_DEFAULT
) ();
    localparam int cwidth = $clog2(nwords + 3);

    logic [nbits-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [nbits-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [cwidth-1:0] count;

    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, count);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, count);
endinterface

// File: rtl/sram_fifo_skid2.sv
// Two-entry register queue; head is always entry 0, new data lands behind it.
module fifo_skid2 #(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             push,
    input  logic [nbits-1:0] push_data,
    input  logic             pop,
    output logic [nbits-1:0] head,
    output logic [1:0]       cnt
);
    logic [nbits-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (pop) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
        end
        // Push goes into the first free slot after any pop has shifted.
        if (push) begin
            if (cnt_d == 2'd0) ent0_d = push_data;
            else               ent1_d = push_data;
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head = ent0_q;
    assign cnt  = cnt_q;
endmodule

// File: rtl/sram_generic.sv
// Behavioural two-port SRAM, one-cycle registered read latency on each port.
module sram_generic #(
    parameter int nbits  = 32,
    parameter int nwords = 512,
    parameter int awidth = $clog2(nwords)
) (
    input  logic              clk,
    input  logic              wren_1,
    input  logic              rden_1,
    input  logic [awidth-1:0] addr_1,
    input  logic [nbits-1:0]  data_1,
    output logic [nbits-1:0]  q_1,
    input  logic              wren_2,
    input  logic              rden_2,
    input  logic [awidth-1:0] addr_2,
    input  logic [nbits-1:0]  data_2,
    output logic [nbits-1:0]  q_2
);
    logic [nbits-1:0] mem [nwords];

    always_ff @(posedge clk) begin
        if (wren_1) mem[addr_1] <= data_1;
        if (wren_2) mem[addr_2] <= data_2;
        if (rden_1) q_1 <= mem[addr_1];
        if (rden_2) q_2 <= mem[addr_2];
    end
endmodule

// File: rtl/sram_fifo.sv
// Streaming FIFO over a two-port SRAM: port 1 writes, port 2 reads into a
// two-entry skid so the consumer sees one word per cycle despite read latency.
module sram_fifo import sram_fifo_pkg::*; #(
    parameter int nbits  = NBITS_DEFAULT,
    parameter int nwords = NWORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rstb,
    sram_fifo_if.slave  bus
);
    localparam int awidth = $clog2(nwords);
    localparam int cwidth = $clog2(nwords + 3);

    logic [awidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [awidth:0]   sram_cnt_q, sram_cnt_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              push, pop, rd_issue;
    logic [1:0]        skid_cnt;
    logic [nbits-1:0]  q_2;
    logic [nbits-1:0]  q_1_unused;

    assign bus.in_ready  = (sram_cnt_q != (awidth+1)'(nwords));
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign rd_issue      = (sram_cnt_q != '0) && skid_has_room(skid_cnt, rd_inflight_q, pop);
    assign bus.out_valid = (skid_cnt != 2'd0);
    assign bus.count     = cwidth'(sram_cnt_q) + cwidth'(rd_inflight_q) + cwidth'(skid_cnt);

    always_comb begin
        wr_ptr_d      = wr_ptr_q + awidth'(push);
        rd_ptr_d      = rd_ptr_q + awidth'(rd_issue);
        sram_cnt_d    = sram_cnt_q + (awidth+1)'(push) - (awidth+1)'(rd_issue);
        rd_inflight_d = rd_issue;
    end

    // Reset drops any outstanding read; its q_2 is simply never captured.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sram_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            sram_cnt_q    <= sram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    sram_generic #(.nbits(nbits), .nwords(nwords)) u_sram (
        .clk    (clk),
        .wren_1 (push),
        .rden_1 (1'b0),
        .addr_1 (wr_ptr_q),
        .data_1 (bus.in_data),
        .q_1    (q_1_unused),
        .wren_2 (1'b0),
        .rden_2 (rd_issue),
        .addr_2 (rd_ptr_q),
        .data_2 ('0),
        .q_2    (q_2)
    );

    fifo_skid2 #(.nbits(nbits)) u_skid (
        .clk       (clk),
        .rstb      (rstb),
        .push      (rd_inflight_q),
        .push_data (q_2),
        .pop       (pop),
        .head      (bus.out_data),
        .cnt       (skid_cnt)
    );
endmodule

// File: tb/tb_sram_fifo.sv
// Bench for sram_fifo: occupancy/queue model checked every cycle plus directed literal checks.
module tb_sram_fifo;
    import sram_fifo_pkg::*;

    localparam int NB = 32;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    sram_fifo_if #(.nbits(NB), .nwords(NW)) bus ();
    sram_fifo #(.nbits(NB), .nwords(NW)) dut (.clk(clk), .rstb(rstb), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // Model: words held at each stage, and the data order as a plain queue.
    int m_sram = 0, m_infl = 0, m_skid = 0;
    logic [NB-1:0] mq[$];
    logic [NB-1:0] got[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_sram = 0; m_infl = 0; m_skid = 0;
            mq.delete();
        end else begin
            int push_i, pop_i, issue_i;
            push_i  = (bus.in_valid && (m_sram < NW)) ? 1 : 0;
            pop_i   = (bus.out_ready && (m_skid > 0)) ? 1 : 0;
            issue_i = ((m_sram > 0) && (m_skid + m_infl - pop_i < 2)) ? 1 : 0;
            if (pop_i == 1) void'(mq.pop_front());
            if (push_i == 1) mq.push_back(bus.in_data);
            m_skid = m_skid - pop_i + m_infl;
            m_infl = issue_i;
            m_sram = m_sram + push_i - issue_i;
        end
    end

    always @(negedge clk) begin
        if (rstb) begin
            chk("out_valid", bus.out_valid, m_skid > 0);
            chk("in_ready", bus.in_ready, m_sram < NW);
            chk("count", bus.count, mq.size());
            chk("count_bound", bus.count <= NW + 2, 1);
            if (m_skid > 0) chk("out_data", bus.out_data, mq[0]);
            if (dut.push && dut.rd_issue) chk("addr_collision", dut.wr_ptr_q != dut.rd_ptr_q, 1);
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
        end
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        int k, drops, gaps, cyc, acc, extra, bad;
        bit seen;
        logic [NB-1:0] drain_exp [6];
        drain_exp = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h200};
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_sram_en", {dut.push, dut.rd_issue}, 0);
        rstb = 1'b1;
        @(posedge clk); #1;

        // Single word fall-through
        bus.out_ready = 1'b1; bus.in_data = 32'hDEADBEEF; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("ft_count_t", bus.count, 1);
        chk("ft_valid_t", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("ft_valid_t1", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("ft_valid_t2", bus.out_valid, 1);
        chk("ft_data", bus.out_data, 32'hDEADBEEF);
        chk("ft_count_t2", bus.count, 1);
        @(posedge clk); #1;
        chk("ft_count_end", bus.count, 0);
        chk("ft_valid_end", bus.out_valid, 0);

        // Back-to-back streaming
        got.delete();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        k = 0; drops = 0; gaps = 0; cyc = 0; seen = 0;
        while (k < 1024 && cyc < 3000) begin
            bus.in_data = 32'h1000_0000 + k;
            @(negedge clk);
            if (seen && !bus.out_valid) gaps++;
            if (bus.out_valid) seen = 1;
            if (bus.in_ready) k++; else drops++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        cyc = 0;
        while (bus.count != 0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("stream_in_ready_drops", drops, 0);
        chk("stream_gaps", gaps, 0);
        chk("stream_words", got.size(), 1024);
        bad = 0;
        foreach (got[i]) if (got[i] !== 32'h1000_0000 + i) bad++;
        chk("stream_order_errors", bad, 0);

        // Fill until full with consumer stalled
        got.delete();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; acc = 0;
        for (int i = 0; i < 40; i++) begin
            bus.in_data = 32'h100 + acc;
            @(negedge clk);
            if (!bus.in_ready) break;
            @(posedge clk); #1;
            acc++;
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("full_accepts", acc, 6);
        chk("full_count", bus.count, 6);
        chk("full_in_ready", bus.in_ready, 0);

        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("one_pop_words", got.size(), 1);
        chk("one_pop_data", (got.size() > 0) ? got[0] : '1, 32'h100);
        bus.in_data = 32'h200; bus.in_valid = 1'b1; extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.in_ready) extra++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("refill_accepts", extra, 1);
        chk("refill_count", bus.count, 6);

        // Drain with no pushes
        got.delete();
        bus.out_ready = 1'b1; cyc = 0;
        while (bus.count != 0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        chk("drain_words", got.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("drain_data", (i < got.size()) ? got[i] : '1, drain_exp[i]);
        chk("drain_count", bus.count, 0);
        chk("drain_valid", bus.out_valid, 0);

        // Random traffic
        void'($urandom(1000));
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid  = $urandom_range(0, 1) == 1;
            bus.out_ready = $urandom_range(0, 1) == 1;
            bus.in_data   = $urandom;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("random_final_count", bus.count, 0);

        // Asynchronous reset with a read outstanding
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = 32'h5000 + i;
            @(posedge clk); #1;
        end
        chk("rst_pre_inflight", dut.rd_inflight_q, 1);
        #2 rstb = 1'b0;
        #1;
        bus.in_valid = 1'b0;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_count", bus.count, 0);
        chk("arst_out_data", bus.out_data, 0);
        @(posedge clk); #3 rstb = 1'b1;
        got.delete();
        @(posedge clk); #1;
        bus.in_data = 32'h1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_words", got.size(), 1);
        chk("post_rst_data", (got.size() > 0) ? got[0] : '1, 32'h1);
        chk("post_rst_count", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
